// File: rtl/lr_pkg.sv
// lr_pkg: window geometry shared by the 9x9 line buffer and the 81-tap inner product.
package lr_pkg;
  localparam int PIX_W = 7;
  localparam int K = 9;
  localparam int KK = K * K;
  localparam int WIN_BITS = KK * PIX_W;
  function automatic int win_idx(input int r, input int c);
    return r * K + c;
  endfunction
endpackage

// File: rtl/window_linebuffer9_line_delay.sv
// line_delay: one image row of delay, advancing only on accepted pixels.
module line_delay #(
  parameter int DEPTH = 28,
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [DEPTH*W-1:0] sh_q, sh_d;
  always_comb sh_d = en ? {sh_q[(DEPTH-1)*W-1:0], din} : sh_q;
  always_ff @(posedge clk) sh_q <= sh_d;
  assign dout = sh_q[DEPTH*W-1 -: W];
endmodule

// File: rtl/window_linebuffer9.sv
// window_linebuffer9: raster pixel stream to 9x9 sliding windows, one per accepted pixel
// once K-1 rows and K-1 columns are buffered.
module window_linebuffer9
  import lr_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pix_valid,
  input  logic [PIX_W-1:0]           pix_data,
  input  logic                       pix_sof,
  output logic                       win_valid,
  output logic [WIN_BITS-1:0]        win_data,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  output logic                       frame_done
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  logic [K-1:0][PIX_W-1:0] tap;
  logic [RW-1:0] row_q, row_d, pos_r, wrow_q, wrow_d;
  logic [CW-1:0] col_q, col_d, pos_c, wcol_q, wcol_d;
  logic [WIN_BITS-1:0] win_q, win_d, out_q, out_d;
  logic valid_q, valid_d, done_q, done_d, last_r, last_c, hit;
  assign tap[0] = pix_data;
  for (genvar g = 0; g < K - 1; g++) begin : g_ld
    line_delay #(.DEPTH(IMG_W), .W(PIX_W)) u_ld (
      .clk (clk),
      .en  (pix_valid),
      .din (tap[g]),
      .dout(tap[g+1])
    );
  end
  // Window rows shift left; the newest column enters at c = K-1, oldest row at r = 0.
  always_comb begin
    win_d = win_q;
    if (pix_valid) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++)
          win_d[PIX_W*win_idx(r, c) +: PIX_W] = win_q[PIX_W*win_idx(r, c + 1) +: PIX_W];
        win_d[PIX_W*win_idx(r, K - 1) +: PIX_W] = tap[K-1-r];
      end
    end
  end
  // sof relocates the accepted pixel to (0,0) regardless of the counters.
  always_comb begin
    pos_r = pix_sof ? '0 : row_q;
    pos_c = pix_sof ? '0 : col_q;
    last_r = pos_r == RW'(IMG_H - 1);
    last_c = pos_c == CW'(IMG_W - 1);
    hit = pix_valid && pos_r >= RW'(K - 1) && pos_c >= CW'(K - 1);
    col_d = pix_valid ? (last_c ? '0 : pos_c + 1'b1) : col_q;
    row_d = (pix_valid && last_c) ? (last_r ? '0 : pos_r + 1'b1) : (pix_valid ? pos_r : row_q);
    valid_d = hit;
    done_d = hit && last_r && last_c;
    out_d = hit ? win_d : out_q;
    wrow_d = hit ? pos_r - RW'(K - 1) : wrow_q;
    wcol_d = hit ? pos_c - CW'(K - 1) : wcol_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
      win_q <= '0;
      out_q <= '0;
      wrow_q <= '0;
      wcol_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      win_q <= win_d;
      out_q <= out_d;
      wrow_q <= wrow_d;
      wcol_q <= wcol_d;
      valid_q <= valid_d;
      done_q <= done_d;
    end
  end
  assign win_valid = valid_q;
  assign frame_done = done_q;
  assign win_data = out_q;
  assign win_row = wrow_q;
  assign win_col = wcol_q;
endmodule

// File: tb/tb_window_linebuffer9.sv
// tb_window_linebuffer9: scoreboard bench for the 9x9 window line buffer.
module tb_window_linebuffer9;
  import lr_pkg::*;
  localparam int IW = 28;
  localparam int IH = 28;
  logic clk = 0, rst_n = 1, pix_valid = 0, pix_sof = 0;
  logic [PIX_W-1:0] pix_data = '0;
  logic win_valid, frame_done;
  logic [WIN_BITS-1:0] win_data;
  logic [4:0] win_row, win_col;
  always #5 clk = ~clk;
  window_linebuffer9 #(.IMG_W(IW), .IMG_H(IH)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof),
    .win_valid(win_valid), .win_data(win_data), .win_row(win_row), .win_col(win_col),
    .frame_done(frame_done)
  );
  typedef struct {
    logic [WIN_BITS-1:0] data;
    int row;
    int col;
    bit fd;
  } exp_t;
  typedef struct {
    int idx;
    int val;
  } tv_t;
  exp_t q[$];
  tv_t tv[6];
  int checks = 0, errors = 0;
  bit exp_pending = 0, got_first = 0;
  int mr = 0, mc = 0, nwin = 0, nfd = 0, acc = 0, first_at = 0, lrow = 0, lcol = 0;
  logic [PIX_W-1:0] img[IH][IW];
  logic [WIN_BITS-1:0] first_win;
  function automatic logic [PIX_W-1:0] pixf(int r, int c, int f);
    return PIX_W'((r * IW + c + f * 53) % 128);
  endfunction
  task automatic chk(string n, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic check_out();
    exp_t e;
    chk("win_valid timing", int'(win_valid), int'(exp_pending));
    if (win_valid === 1'b1) begin
      if (q.size() == 0) chk("unexpected window", 1, 0);
      else begin
        e = q.pop_front();
        nwin++;
        if (frame_done === 1'b1) nfd++;
        checks++;
        if (win_data !== e.data) begin
          errors++;
          $display("FAIL win_data: got %h expected %h", win_data, e.data);
        end
        chk("win_row", int'(win_row), e.row);
        chk("win_col", int'(win_col), e.col);
        chk("frame_done", int'(frame_done), int'(e.fd));
        lrow = int'(win_row);
        lcol = int'(win_col);
        if (!got_first) begin
          got_first = 1;
          first_win = win_data;
          first_at = acc;
        end
      end
    end else chk("frame_done idle", int'(frame_done), 0);
  endtask
  task automatic drive(bit v, bit s, int f);
    exp_t e;
    @(negedge clk);
    check_out();
    pix_valid = v;
    pix_sof = s;
    exp_pending = 0;
    if (v) begin
      acc++;
      if (s) begin
        mr = 0;
        mc = 0;
      end
      pix_data = pixf(mr, mc, f);
      img[mr][mc] = pix_data;
      if (mr >= K - 1 && mc >= K - 1) begin
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            e.data[PIX_W*(r*K+c) +: PIX_W] = img[mr-K+1+r][mc-K+1+c];
        e.row = mr - (K - 1);
        e.col = mc - (K - 1);
        e.fd = (mr == IH - 1) && (mc == IW - 1);
        q.push_back(e);
        exp_pending = 1;
      end
      if (mc == IW - 1) begin
        mc = 0;
        mr = (mr == IH - 1) ? 0 : mr + 1;
      end else mc++;
    end else pix_data = PIX_W'($urandom);
  endtask
  task automatic pixels(int f, int n, bit sof, bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) while ($urandom_range(0, 1) == 1) drive(0, 0, f);
      drive(1, sof && i == 0, f);
    end
  endtask
  task automatic flush();
    repeat (2) drive(0, 0, 0);
  endtask
  initial begin
    tv[0] = '{0, 0};
    tv[1] = '{80, 104};
    tv[2] = '{8, 8};
    tv[3] = '{72, 96};
    tv[4] = '{10, 29};
    tv[5] = '{40, 116};
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("reset win_valid", int'(win_valid), 0);
    chk("reset frame_done", int'(frame_done), 0);
    chk("reset win_data zero", int'(win_data == '0), 1);
    chk("reset win_row", int'(win_row), 0);
    chk("reset win_col", int'(win_col), 0);
    rst_n = 1;
    // Continuous frame with the reference pixel pattern.
    pixels(0, IW * IH, 1, 0);
    flush();
    chk("frame0 windows", nwin, 400);
    chk("frame0 frame_done", nfd, 1);
    chk("frame0 last row", lrow, 19);
    chk("frame0 last col", lcol, 19);
    chk("first window accept count", first_at, 233);
    for (int i = 0; i < 6; i++)
      chk($sformatf("xarray[%0d]", tv[i].idx), int'(first_win[PIX_W*tv[i].idx +: PIX_W]), tv[i].val);
    // Two back-to-back frames.
    nwin = 0;
    nfd = 0;
    pixels(1, IW * IH, 1, 0);
    pixels(2, IW * IH, 1, 0);
    flush();
    chk("b2b windows", nwin, 800);
    chk("b2b frame_done", nfd, 2);
    // Random valid gaps.
    nwin = 0;
    nfd = 0;
    pixels(0, IW * IH, 1, 1);
    flush();
    chk("gapped windows", nwin, 400);
    chk("gapped frame_done", nfd, 1);
    // sof at row 12 col 5 abandons the frame.
    nwin = 0;
    nfd = 0;
    pixels(3, 12 * IW + 5, 1, 0);
    chk("abandoned windows", nwin + q.size(), 80);
    pixels(4, IW * IH, 1, 0);
    flush();
    chk("sof restart windows", nwin, 480);
    chk("sof restart frame_done", nfd, 1);
    // Asynchronous reset mid-frame, restarted frame without sof.
    pixels(5, 15 * IW + 10, 1, 0);
    @(posedge clk);
    #1 chk("pre-reset win_valid", int'(win_valid), 1);
    #1 rst_n = 0;
    #1;
    chk("async reset win_valid", int'(win_valid), 0);
    chk("async reset frame_done", int'(frame_done), 0);
    chk("async reset win_data zero", int'(win_data == '0), 1);
    chk("async reset win_row", int'(win_row), 0);
    q.delete();
    exp_pending = 0;
    mr = 0;
    mc = 0;
    pix_valid = 0;
    pix_sof = 0;
    @(negedge clk);
    rst_n = 1;
    nwin = 0;
    nfd = 0;
    pixels(6, IW * IH, 0, 0);
    flush();
    chk("post-reset windows", nwin, 400);
    chk("post-reset frame_done", nfd, 1);
    chk("scoreboard empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
